// File: rtl/param_register_file_if.sv
// Register-file access bundle: two read ports, two write ports and the
// clear-sweep status flag. The pipeline side drives addresses and write data
// (master); the register file returns read data and Busy (slave).
interface param_register_file_if #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [WIDTH-1:0]  BusA;
    logic [WIDTH-1:0]  BusB;
    logic [ADDR_W-1:0] RW0;
    logic [WIDTH-1:0]  BusW0;
    logic              RegWr0;
    logic [ADDR_W-1:0] RW1;
    logic [WIDTH-1:0]  BusW1;
    logic              RegWr1;
    logic              Busy;

    modport master (
        output RA, RB, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1,
        input  BusA, BusB, Busy
    );

    modport slave (
        input  RA, RB, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1,
        output BusA, BusB, Busy
    );
endinterface

// File: rtl/param_register_file.sv
// Parametrised dual-write, dual-read register file.
// After Reset a sweep zeroes one entry per cycle; while it runs, writes are
// ignored and both read buses return 0. Once ready, reads are combinational
// with same-cycle write bypass (port 1 beats port 0), and an optional
// hardwired-zero register drops writes and always reads 0.
module param_register_file #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_REG = 31
) (
    input  logic                 Clk,
    input  logic                 Reset,
    param_register_file_if.slave rf
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic              ZERO_EN  = (HAS_ZERO != 0);

    state_t            state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              busy_r;
    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [WIDTH-1:0]  bus_a_s;
    logic [WIDTH-1:0]  bus_b_s;

    // True when the index is the hardwired-zero register (if one is configured)
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_EN && (addr == ZERO_IDX);
    endfunction

    // A write lands only if enabled and not aimed at the hardwired-zero entry
    function automatic logic write_ok(input logic we, input logic [ADDR_W-1:0] addr);
        return we && !is_zero_reg(addr);
    endfunction

    // Read value for one port: sweep forces 0, zero register forces 0,
    // otherwise an in-flight write to the same index is forwarded (port 1 first)
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              busy,
        input logic              we0,
        input logic [ADDR_W-1:0] rw0,
        input logic [WIDTH-1:0]  w0,
        input logic              we1,
        input logic [ADDR_W-1:0] rw1,
        input logic [WIDTH-1:0]  w1
    );
        logic [WIDTH-1:0] val;
        if (busy || is_zero_reg(addr)) begin
            val = '0;
        end else if (we1 && (rw1 == addr)) begin
            val = w1;
        end else if (we0 && (rw0 == addr)) begin
            val = w0;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Clear-sweep FSM, Busy flag and register writes in one clocked process
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    mem_r[cnt_r] <= '0;
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_READY;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_r + ADDR_W'(1);
                        busy_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    busy_r <= 1'b0;
                    // Port 1 is assigned last so it wins when both hit one index
                    if (write_ok(rf.RegWr0, rf.RW0)) begin
                        mem_r[rf.RW0] <= rf.BusW0;
                    end
                    if (write_ok(rf.RegWr1, rf.RW1)) begin
                        mem_r[rf.RW1] <= rf.BusW1;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    cnt_r   <= '0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    // Combinational read ports with write bypass
    always_comb begin
        bus_a_s = '0;
        bus_b_s = '0;
        bus_a_s = read_port(rf.RA, mem_r[rf.RA], busy_r,
                            rf.RegWr0, rf.RW0, rf.BusW0,
                            rf.RegWr1, rf.RW1, rf.BusW1);
        bus_b_s = read_port(rf.RB, mem_r[rf.RB], busy_r,
                            rf.RegWr0, rf.RW0, rf.BusW0,
                            rf.RegWr1, rf.RW1, rf.BusW1);
    end

    assign rf.BusA = bus_a_s;
    assign rf.BusB = bus_b_s;
    assign rf.Busy = busy_r;

endmodule
